// File: rtl/cache_pkg.sv
// Shared definitions for the cache line refill controller: default geometry
// and the refill FSM state encoding.
package cache_pkg;

    localparam int ADDR_W_DEF     = 32;
    localparam int LINE_BYTES_DEF = 4;
    localparam int WAYS_DEF       = 4;
    localparam int SET_W_DEF      = 2;

    localparam int OFFS_W = $clog2(LINE_BYTES_DEF);
    localparam int TAG_W  = ADDR_W_DEF - SET_W_DEF - OFFS_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } fill_state_t;

endpackage

// File: rtl/fill_write_decoder.sv
// Maps {way, byte offset, beat enable} to a one-hot per-byte write strobe.
// The strobe index is way*LINE_BYTES+off; since LINE_BYTES is a power of two
// this is simply the concatenation {way, off}. Purely combinational; the
// parent registers the result.
module fill_write_decoder
    import cache_pkg::*;
#(
    parameter int WAYS       = WAYS_DEF,
    parameter int LINE_BYTES = LINE_BYTES_DEF
) (
    input  logic [$clog2(WAYS)-1:0]       way,
    input  logic [$clog2(LINE_BYTES)-1:0] off,
    input  logic                          beat_en,
    output logic [WAYS*LINE_BYTES-1:0]    byte_write
);

    localparam int STRB_W = WAYS * LINE_BYTES;
    localparam logic [STRB_W-1:0] ONE = STRB_W'(1);

    // one strobe bit per accepted beat, none otherwise
    always_comb begin
        byte_write = '0;
        if (beat_en) begin
            byte_write = ONE << {way, off};
        end
    end

endmodule

// File: rtl/cache_line_fill.sv
// Refill controller: on a miss, requests one line from memory, writes each
// returned byte into the data array through a one-hot strobe, then commits
// tag/valid for the victim way.
// Build option: CACHE_CRITICAL_BYTE_FIRST_EN -- burst starts at the missing
// byte and wraps within the line; otherwise the burst starts at offset 0.
//
// state | meaning
// IDLE  | ready for a miss; latches address, way, set, tag on miss_valid
// REQ   | memory read request held until mem_req_ready
// FILL  | counting LINE_BYTES response beats, one strobe per beat
// DONE  | single cycle: tag_write / fill_done, last byte strobe lands here
module cache_line_fill
    import cache_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int LINE_BYTES = LINE_BYTES_DEF,
    parameter int WAYS       = WAYS_DEF,
    parameter int SET_W      = SET_W_DEF
) (
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic                                           miss_valid,
    output logic                                           miss_ready,
    input  logic [ADDR_W-1:0]                              miss_addr,
    input  logic [$clog2(WAYS)-1:0]                        miss_way,
    output logic                                           mem_req_valid,
    input  logic                                           mem_req_ready,
    output logic [ADDR_W-1:0]                              mem_req_addr,
    input  logic                                           mem_rsp_valid,
    input  logic [7:0]                                     mem_rsp_data,
    output logic [WAYS*LINE_BYTES-1:0]                     byte_write,
    output logic [7:0]                                     byte_data,
    output logic [SET_W-1:0]                               fill_set,
    output logic                                           tag_write,
    output logic [ADDR_W-SET_W-$clog2(LINE_BYTES)-1:0]     fill_tag,
    output logic [$clog2(WAYS)-1:0]                        fill_way,
    output logic                                           fill_busy,
    output logic                                           fill_done
);

    localparam int FILL_OFFS_W = $clog2(LINE_BYTES);
    localparam int FILL_TAG_W  = ADDR_W - SET_W - FILL_OFFS_W;
    localparam int STRB_W      = WAYS * LINE_BYTES;
    localparam logic [FILL_OFFS_W-1:0] LAST_BEAT = FILL_OFFS_W'(LINE_BYTES - 1);

    fill_state_t state, state_next;

    logic [FILL_OFFS_W-1:0] beat_cnt;
    logic [FILL_OFFS_W-1:0] start_off;
    logic [FILL_OFFS_W-1:0] wr_off;
    logic [STRB_W-1:0]      strobe_next;
    logic                   accept;
    logic                   beat_en;
    logic                   last_beat;

    assign accept    = (state == IDLE) && miss_valid;
    assign beat_en   = (state == FILL) && mem_rsp_valid;
    assign last_beat = beat_en && (beat_cnt == LAST_BEAT);
    // offset arithmetic wraps naturally at the line boundary
    assign wr_off    = start_off + beat_cnt;

    // state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (miss_valid)    state_next = REQ;
            REQ:     if (mem_req_ready) state_next = FILL;
            FILL:    if (last_beat)     state_next = DONE;
            DONE:                       state_next = IDLE;
            default:                    state_next = IDLE;
        endcase
    end

    // state-decoded outputs
    always_comb begin
        miss_ready    = 1'b0;
        mem_req_valid = 1'b0;
        tag_write     = 1'b0;
        fill_done     = 1'b0;
        fill_busy     = 1'b1;
        case (state)
            IDLE: begin
                miss_ready = 1'b1;
                fill_busy  = 1'b0;
            end
            REQ:  mem_req_valid = 1'b1;
            DONE: begin
                tag_write = 1'b1;
                fill_done = 1'b1;
            end
            default: ;
        endcase
    end

    // capture the miss context when a miss is accepted
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_req_addr <= '0;
            fill_set     <= '0;
            fill_tag     <= '0;
            fill_way     <= '0;
        end else if (accept) begin
            fill_set <= miss_addr[FILL_OFFS_W +: SET_W];
            fill_tag <= miss_addr[ADDR_W-1 -: FILL_TAG_W];
            fill_way <= miss_way;
`ifdef CACHE_CRITICAL_BYTE_FIRST_EN
            mem_req_addr <= miss_addr;
`else
            mem_req_addr <= {miss_addr[ADDR_W-1:FILL_OFFS_W], {FILL_OFFS_W{1'b0}}};
`endif
        end
    end

`ifdef CACHE_CRITICAL_BYTE_FIRST_EN
    // burst begins at the missing byte
    always_ff @(posedge clk) begin
        if (reset) begin
            start_off <= '0;
        end else if (accept) begin
            start_off <= miss_addr[FILL_OFFS_W-1:0];
        end
    end
`else
    assign start_off = '0;
`endif

    // beat counter, restarted for every new miss
    always_ff @(posedge clk) begin
        if (reset) begin
            beat_cnt <= '0;
        end else if (accept) begin
            beat_cnt <= '0;
        end else if (beat_en) begin
            beat_cnt <= beat_cnt + 1'b1;
        end
    end

    fill_write_decoder #(
        .WAYS       (WAYS),
        .LINE_BYTES (LINE_BYTES)
    ) u_write_decoder (
        .way        (fill_way),
        .off        (wr_off),
        .beat_en    (beat_en),
        .byte_write (strobe_next)
    );

    // register strobe and data one cycle after each beat
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_write <= '0;
            byte_data  <= '0;
        end else begin
            byte_write <= strobe_next;
            if (beat_en) begin
                byte_data <= mem_rsp_data;
            end
        end
    end

endmodule

// File: tb/tb_cache_line_fill.sv
// Scoreboard bench for cache_line_fill: the stimulus tasks push expected
// strobes, tag commits and memory requests; a negedge monitor pops and
// compares whenever the DUT presents one.
module tb_cache_line_fill;

    logic        clk = 1'b0;
    logic        reset;
    logic        miss_valid;
    logic        miss_ready;
    logic [31:0] miss_addr;
    logic [1:0]  miss_way;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [7:0]  mem_rsp_data;
    logic [15:0] byte_write;
    logic [7:0]  byte_data;
    logic [1:0]  fill_set;
    logic        tag_write;
    logic [27:0] fill_tag;
    logic [1:0]  fill_way;
    logic        fill_busy;
    logic        fill_done;

    cache_line_fill dut (
        .clk           (clk),
        .reset         (reset),
        .miss_valid    (miss_valid),
        .miss_ready    (miss_ready),
        .miss_addr     (miss_addr),
        .miss_way      (miss_way),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .byte_write    (byte_write),
        .byte_data     (byte_data),
        .fill_set      (fill_set),
        .tag_write     (tag_write),
        .fill_tag      (fill_tag),
        .fill_way      (fill_way),
        .fill_busy     (fill_busy),
        .fill_done     (fill_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         idx;
        logic [7:0] data;
        int         cyc;
    } wr_t;

    typedef struct {
        logic [1:0]  set;
        logic [27:0] tag;
        logic [1:0]  way;
        int          cyc;
    } tag_t;

    wr_t         wq[$];
    tag_t        tq[$];
    logic [31:0] rq[$];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor: compare whatever the DUT presents against the scoreboard
    always @(negedge clk) begin
        int   idx;
        wr_t  we;
        tag_t te;
        logic [31:0] re;
        if (byte_write != '0) begin
            idx = -1;
            for (int i = 0; i < 16; i++) if (byte_write[i]) idx = i;
            chk("strobe_onehot", $countones(byte_write), 1);
            if (wq.size() == 0) begin
                chk("stray_strobe", byte_write, 0);
            end else begin
                we = wq.pop_front();
                chk("strobe_idx", idx, we.idx);
                chk("strobe_data", byte_data, we.data);
                chk("strobe_cycle", cyc, we.cyc);
            end
        end
        if (tag_write) begin
            if (tq.size() == 0) begin
                chk("stray_tag_write", tag_write, 0);
            end else begin
                te = tq.pop_front();
                chk("tag_set", fill_set, te.set);
                chk("tag_tag", fill_tag, te.tag);
                chk("tag_way", fill_way, te.way);
                chk("tag_cycle", cyc, te.cyc);
                chk("fill_done_with_tag", fill_done, 1);
            end
        end else if (fill_done) begin
            chk("stray_fill_done", fill_done, 0);
        end
        if (mem_req_valid && mem_req_ready) begin
            if (rq.size() == 0) begin
                chk("stray_mem_req", mem_req_valid, 0);
            end else begin
                re = rq.pop_front();
                chk("mem_req_addr", mem_req_addr, re);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // one complete (or partial, if fewer than 4 beats) line fill
    task automatic run_fill(
        input  logic [31:0] addr,
        input  logic [1:0]  way,
        input  logic [31:0] exp_req,
        input  logic [1:0]  exp_set,
        input  logic [27:0] exp_tag,
        input  int          hold,
        input  logic [15:0] pat,
        input  int          plen,
        input  logic [7:0]  data0,
        input  bit          keep_miss,
        input  bit          rsp_in_req,
        output int          acc_cyc
    );
        int         k;
        int         tries;
        logic [1:0] so;
        wr_t        w;
        tag_t       t;
`ifdef CACHE_CRITICAL_BYTE_FIRST_EN
        so = addr[1:0];
`else
        so = 2'd0;
`endif
        acc_cyc    = -1;
        rq.push_back(exp_req);
        miss_valid = 1'b1;
        miss_addr  = addr;
        miss_way   = way;
        tries      = 0;
        while (!miss_ready && tries < 50) begin
            step();
            tries++;
        end
        if (!miss_ready) begin
            chk("miss_accept_timeout", miss_ready, 1);
            miss_valid = 1'b0;
            return;
        end
        acc_cyc = cyc;
        step();
        if (!keep_miss) miss_valid = 1'b0;
        for (int h = 0; h < hold; h++) begin
            mem_req_ready = 1'b0;
            mem_rsp_valid = rsp_in_req;
            mem_rsp_data  = 8'hEE;
            chk("req_valid_hold", mem_req_valid, 1);
            chk("req_addr_hold", mem_req_addr, exp_req);
            if (keep_miss) chk("miss_ready_req", miss_ready, 0);
            step();
        end
        mem_rsp_valid = 1'b0;
        mem_req_ready = 1'b1;
        chk("req_valid", mem_req_valid, 1);
        step();
        mem_req_ready = 1'b0;
        k = 0;
        for (int i = 0; i < plen; i++) begin
            mem_rsp_valid = pat[i];
            mem_rsp_data  = data0 + 8'(k);
            chk("busy_fill", fill_busy, 1);
            if (keep_miss) chk("miss_ready_fill", miss_ready, 0);
            if (pat[i]) begin
                w.idx  = int'(way) * 4 + ((int'(so) + k) % 4);
                w.data = data0 + 8'(k);
                w.cyc  = cyc + 1;
                wq.push_back(w);
                k++;
                if (k == 4) begin
                    t.set = exp_set;
                    t.tag = exp_tag;
                    t.way = way;
                    t.cyc = cyc + 1;
                    tq.push_back(t);
                end
            end
            step();
        end
        mem_rsp_valid = 1'b0;
        if (keep_miss) chk("miss_ready_done", miss_ready, 0);
    endtask

    task automatic drain();
        repeat (3) step();
        chk("strobe_queue_empty", wq.size(), 0);
        chk("tag_queue_empty", tq.size(), 0);
        chk("req_queue_empty", rq.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int done_cyc;
        reset         = 1'b1;
        miss_valid    = 1'b0;
        miss_addr     = '0;
        miss_way      = '0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        repeat (3) step();
        reset = 1'b0;

        chk("rst_miss_ready", miss_ready, 1);
        chk("rst_req_valid", mem_req_valid, 0);
        chk("rst_req_addr", mem_req_addr, 0);
        chk("rst_byte_write", byte_write, 0);
        chk("rst_byte_data", byte_data, 0);
        chk("rst_tag_write", tag_write, 0);
        chk("rst_fill_done", fill_done, 0);
        chk("rst_fill_busy", fill_busy, 0);
        chk("rst_fill_set", fill_set, 0);
        chk("rst_fill_tag", fill_tag, 0);
        chk("rst_fill_way", fill_way, 0);

        // basic fill, memory ready at once, four consecutive beats
`ifdef CACHE_CRITICAL_BYTE_FIRST_EN
        run_fill(32'h26, 2'd2, 32'h26, 2'd1, 28'h2, 0, 16'hF, 4, 8'hA0, 1'b0, 1'b0, acc);
`else
        run_fill(32'h26, 2'd2, 32'h24, 2'd1, 28'h2, 0, 16'hF, 4, 8'hA0, 1'b0, 1'b0, acc);
`endif
        drain();

        // memory request stalled for five cycles
`ifdef CACHE_CRITICAL_BYTE_FIRST_EN
        run_fill(32'h1235, 2'd1, 32'h1235, 2'd1, 28'h123, 5, 16'hF, 4, 8'h10, 1'b0, 1'b0, acc);
`else
        run_fill(32'h1235, 2'd1, 32'h1234, 2'd1, 28'h123, 5, 16'hF, 4, 8'h10, 1'b0, 1'b0, acc);
`endif
        drain();

        // beats with gaps: 1,0,0,1,1,0,1
        run_fill(32'hABC8, 2'd3, 32'hABC8, 2'd2, 28'hABC, 0, 16'b1011001, 7, 8'h30, 1'b0, 1'b0, acc);
        drain();

        // miss held high through a fill; the repeat is taken right after DONE
`ifdef CACHE_CRITICAL_BYTE_FIRST_EN
        run_fill(32'h53, 2'd1, 32'h53, 2'd0, 28'h5, 1, 16'hF, 4, 8'h50, 1'b1, 1'b0, acc);
        done_cyc = cyc;
        run_fill(32'h53, 2'd1, 32'h53, 2'd0, 28'h5, 0, 16'hF, 4, 8'h60, 1'b0, 1'b0, acc);
`else
        run_fill(32'h53, 2'd1, 32'h50, 2'd0, 28'h5, 1, 16'hF, 4, 8'h50, 1'b1, 1'b0, acc);
        done_cyc = cyc;
        run_fill(32'h53, 2'd1, 32'h50, 2'd0, 28'h5, 0, 16'hF, 4, 8'h60, 1'b0, 1'b0, acc);
`endif
        chk("second_miss_accept_cycle", acc, done_cyc + 1);
        drain();

        // reset after two of four beats
        run_fill(32'h40, 2'd0, 32'h40, 2'd0, 28'h4, 0, 16'h3, 2, 8'h70, 1'b0, 1'b0, acc);
        reset = 1'b1;
        step();
        chk("abort_miss_ready", miss_ready, 1);
        chk("abort_busy", fill_busy, 0);
        chk("abort_byte_write", byte_write, 0);
        chk("abort_tag_write", tag_write, 0);
        reset = 1'b0;

        // response beats while idle are ignored
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 8'hDD;
        step();
        step();
        mem_rsp_valid = 1'b0;
        chk("idle_rsp_miss_ready", miss_ready, 1);
        chk("idle_rsp_busy", fill_busy, 0);

        // new miss after the abort, with response beats during REQ
`ifdef CACHE_CRITICAL_BYTE_FIRST_EN
        run_fill(32'h7F, 2'd3, 32'h7F, 2'd3, 28'h7, 2, 16'hF, 4, 8'h80, 1'b0, 1'b1, acc);
`else
        run_fill(32'h7F, 2'd3, 32'h7C, 2'd3, 28'h7, 2, 16'hF, 4, 8'h80, 1'b0, 1'b1, acc);
`endif
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
